fetch_unit: RTL and testbench

Instruction fetch stage between the PC and decode.
- Drives the read port (port B) of the dual-port instruction BRAM, which has 1-cycle synchronous read latency.
- Captures the returned word and presents {pc, instr} to decode over a valid/ready handshake.
- Handles back-pressure with a 2-entry output buffer, and handles redirects (branch/jump/trap) by flushing.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_skid_buf.sv | 81 ++++++++
 rtl/fetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   INSTR_BYTES      - bytes per instruction (PC step)
//   PC_WIDTH         - byte-address PC width carried in fetch packets
//   DATA_WIDTH       - instruction width carried in fetch packets
//   DEFAULT_RESET_PC - default PC loaded on reset
//   fetch_pkt_t      - {pc, instr} packet handed to decode
//   align_pc()       - clears the byte-offset bits of a PC
package fetch_pkg;

  localparam int unsigned PC_WIDTH    = 32;
  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [PC_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [DATA_WIDTH-1:0] instr;
  } fetch_pkt_t;

  function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] pc);
    return pc & ~PC_WIDTH'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: 2-entry valid/ready buffer of fetch packets.
//   clk, rst_n    - clock, asynchronous active-low reset
//   flush_i       - drop both entries (redirect)
//   in_valid_i    - a packet arrives this cycle (no ready: the producer only
//                   issues a read when a slot is guaranteed)
//   in_pkt_i      - arriving packet
//   out_ready_i   - consumer accepts the presented packet
//   out_valid_o   - presented packet valid
//   out_pkt_o     - presented packet (registered)
//   skid_valid_o  - second entry occupied
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush_i,
  input  logic       in_valid_i,
  input  fetch_pkt_t in_pkt_i,
  input  logic       out_ready_i,
  output logic       out_valid_o,
  output fetch_pkt_t out_pkt_o,
  output logic       skid_valid_o
);

  logic       out_valid_q, out_valid_d;
  logic       skid_valid_q, skid_valid_d;
  fetch_pkt_t out_pkt_q, out_pkt_d;
  fetch_pkt_t skid_pkt_q, skid_pkt_d;
  logic       out_free;

  // Output slot can be loaded when empty or when its packet leaves this cycle.
  assign out_free = ~out_valid_q | out_ready_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_pkt_d    = out_pkt_q;
    skid_valid_d = skid_valid_q;
    skid_pkt_d   = skid_pkt_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        // Older skid entry goes first to keep FIFO order.
        out_valid_d  = 1'b1;
        out_pkt_d    = skid_pkt_q;
        skid_valid_d = in_valid_i;
        if (in_valid_i) begin
          skid_pkt_d = in_pkt_i;
        end
      end else begin
        out_valid_d = in_valid_i;
        if (in_valid_i) begin
          out_pkt_d = in_pkt_i;
        end
      end
    end else if (in_valid_i) begin
      skid_valid_d = 1'b1;
      skid_pkt_d   = in_pkt_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_pkt_q    <= '0;
      skid_pkt_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_pkt_q    <= out_pkt_d;
      skid_pkt_q   <= skid_pkt_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_pkt_o    = out_pkt_q;
  assign skid_valid_o = skid_valid_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage between the PC and decode.
// Reads the instruction BRAM (port B, 1-cycle read latency), buffers returned
// words in a 2-entry skid buffer and presents {pc, instr} to decode with a
// valid/ready handshake. Redirects flush all buffered and in-flight words.
//   clk, rst_n          - clock, asynchronous active-low reset
//   fetch_en            - permit new BRAM reads
//   redirect_valid/pc   - redirect request and target (bits [1:0] ignored)
//   mem_en/addr/we      - BRAM port-B control (we tied low)
//   mem_rdata           - BRAM port-B read data
//   inst_valid/ready    - decode handshake
//   inst_pc, inst_data  - presented packet
// Optional (macro FETCH_PERF_CNT_EN): perf_fetch_cnt, perf_stall_cnt,
// saturating 32-bit counters of transfers and stalled cycles.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned         ADDR_WIDTH = 8,
  parameter int unsigned         DATA_WIDTH = 32,
  parameter int unsigned         PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [PC_WIDTH-1:0]   inst_pc,
  output logic [DATA_WIDTH-1:0] inst_data
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_stall_cnt
`endif
);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                inflight_q, inflight_d;
  logic                skid_valid;
  logic                consume;
  logic                issue;
  logic [1:0]          occ;
  logic [1:0]          free;
  fetch_pkt_t          ret_pkt;
  fetch_pkt_t          out_pkt;

  // Slots claimed by presented, skidded and in-flight words; a slot being
  // handed to decode this cycle counts as released.
  assign consume = inst_valid & inst_ready;
  assign occ     = {1'b0, inst_valid} + {1'b0, skid_valid} + {1'b0, inflight_q};
  assign free    = occ - {1'b0, consume};
  assign issue   = fetch_en & ~redirect_valid & (free < 2'd2);

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      pc_d = align_pc(redirect_pc);
    end else if (issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
      pc_d          = pc_q + PC_WIDTH'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  // BRAM samples the address on the issue edge; data is valid while inflight_q.
  assign mem_en   = rst_n;
  assign mem_we   = 1'b0;
  assign mem_addr = pc_q[ADDR_WIDTH+1:2];

  assign ret_pkt.pc    = inflight_pc_q;
  assign ret_pkt.instr = mem_rdata;

  fetch_skid_buf u_skid_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (redirect_valid),
    .in_valid_i   (inflight_q),
    .in_pkt_i     (ret_pkt),
    .out_ready_i  (inst_ready),
    .out_valid_o  (inst_valid),
    .out_pkt_o    (out_pkt),
    .skid_valid_o (skid_valid)
  );

  assign inst_pc   = out_pkt.pc;
  assign inst_data = out_pkt.instr;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_stall_q;

  // Counts port-level handshakes, including one coinciding with a redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (consume && (perf_fetch_q != '1)) begin
        perf_fetch_q <= perf_fetch_q + 32'd1;
      end
      if (inst_valid && !inst_ready && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`else
  // Performance counters not built.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. Inputs change and outputs
// are sampled on the falling clock edge. A reference model tracks the program
// order PC stream (sequential, restarted by redirects) and the BRAM contents.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_en;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (32),
    .PC_WIDTH   (32),
    .RESET_PC   (RST_PC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_en         (mem_en),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_rdata      (mem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // Instruction BRAM, 1-cycle synchronous read.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem[mem_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [31:0] exp_pc;
  logic [2:0]  hist_redir;
  logic [2:0]  hist_fe;
  logic        prev_stall;
  logic [31:0] prev_pc;
  logic [31:0] prev_data;
  int          mdl_fetch;
  int          mdl_stall;
  int          n_xfer;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return mem[pc[9:2]];
  endfunction

  task automatic model_reset();
    exp_pc     = RST_PC;
    hist_redir = '0;
    hist_fe    = '0;
    prev_stall = 1'b0;
    prev_pc    = '0;
    prev_data  = '0;
    mdl_fetch  = 0;
    mdl_stall  = 0;
  endtask

  // Judges the current cycle against the model, then accounts for what the
  // coming clock edge does with the inputs now applied.
  task automatic monitor();
    if (rst_n) begin
      if (hist_redir[0] || hist_redir[1]) begin
        chk("redirect_bubble", inst_valid, 1'b0);
      end else if (hist_redir[2] && hist_fe[1]) begin
        chk("redirect_refill", inst_valid, 1'b1);
      end
      if (prev_stall) begin
        chk("hold_valid", inst_valid, 1'b1);
        chk("hold_pc", inst_pc, prev_pc);
        chk("hold_data", inst_data, prev_data);
      end
      if (redirect_valid) begin
        exp_pc = redirect_pc & ~32'h3;
      end else if (inst_valid && inst_ready) begin
        chk("xfer_pc", inst_pc, exp_pc);
        chk("xfer_data", inst_data, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        n_xfer++;
      end
      if (inst_valid && inst_ready) mdl_fetch++;
      if (inst_valid && !inst_ready) mdl_stall++;
      prev_stall = inst_valid && !inst_ready && !redirect_valid;
      prev_pc    = inst_pc;
      prev_data  = inst_data;
      hist_redir = {hist_redir[1:0], redirect_valid};
      hist_fe    = {hist_fe[1:0], fetch_en};
    end
  endtask

  task automatic step();
    monitor();
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, input int max_cycles);
    int n = 0;
    while (!inst_valid && n < max_cycles) begin
      step();
      n++;
    end
    chk(tag, inst_valid, 1'b1);
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
    chk("redirect_next_cycle_idle", inst_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
    n_xfer         = 0;
    rst_n          = 1'b0;
    fetch_en       = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    model_reset();
    repeat (3) @(negedge clk);

    chk("reset_valid", inst_valid, 1'b0);
    chk("reset_pc", inst_pc, 32'h0);
    chk("reset_data", inst_data, 32'h0);
    chk("reset_mem_en", mem_en, 1'b0);
    chk("mem_we", mem_we, 1'b0);

    // Reset release: word 0 presented two edges later, then one per cycle.
    rst_n = 1'b1;
    chk("run_mem_en", mem_en, 1'b1);
    step();
    chk("first_edge_idle", inst_valid, 1'b0);
    step();
    chk("first_valid", inst_valid, 1'b1);
    chk("first_pc", inst_pc, 32'h0);
    chk("first_data", inst_data, 32'hA000_0000);
    for (int i = 1; i < 7; i++) begin
      step();
      chk("stream_valid", inst_valid, 1'b1);
      chk("stream_pc", inst_pc, 32'(4 * i));
    end

    // Back-pressure for 5 cycles, then resume at full rate.
    inst_ready = 1'b0;
    repeat (5) step();
    chk("stall_pc", inst_pc, 32'd24);
    chk("stall_data", inst_data, 32'hA000_0006);
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("resume_valid", inst_valid, 1'b1);
      chk("resume_pc", inst_pc, 32'(28 + 4 * i));
    end

    // Redirect while output and skid are both full.
    inst_ready = 1'b0;
    step();
    step();
    redirect_to(32'h40);
    inst_ready = 1'b1;
    wait_valid("redir40_valid", 8);
    chk("redir40_pc", inst_pc, 32'h40);
    chk("redir40_data", inst_data, 32'hA000_0010);
    step();

    // Redirect coinciding with a transfer: the target is presented next.
    chk("redir_xfer_pre_valid", inst_valid, 1'b1);
    redirect_to(32'h80);
    wait_valid("redir80_valid", 8);
    chk("redir80_pc", inst_pc, 32'h80);
    chk("redir80_data", inst_data, 32'hA000_0020);

    // BRAM index wrap.
    redirect_to(32'h3FC);
    wait_valid("wrap_idx_valid", 8);
    chk("wrap_idx_pc0", inst_pc, 32'h3FC);
    chk("wrap_idx_data0", inst_data, 32'hA000_00FF);
    step();
    chk("wrap_idx_pc1", inst_pc, 32'h400);
    chk("wrap_idx_data1", inst_data, 32'hA000_0000);

    // PC wrap; low target bits are ignored.
    redirect_to(32'hFFFF_FFFE);
    wait_valid("wrap_pc_valid", 8);
    chk("wrap_pc_pc0", inst_pc, 32'hFFFF_FFFC);
    chk("wrap_pc_data0", inst_data, 32'hA000_00FF);
    step();
    chk("wrap_pc_pc1", inst_pc, 32'h0);
    chk("wrap_pc_data1", inst_data, 32'hA000_0000);

    // fetch_en low: the in-flight word still arrives, then the stream dries up.
    fetch_en = 1'b0;
    step();
    chk("fe_off_last_valid", inst_valid, 1'b1);
    chk("fe_off_last_pc", inst_pc, 32'h4);
    step();
    chk("fe_off_empty0", inst_valid, 1'b0);
    step();
    chk("fe_off_empty1", inst_valid, 1'b0);
    fetch_en = 1'b1;
    wait_valid("fe_on_valid", 8);
    chk("fe_on_pc", inst_pc, 32'h8);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      fetch_en       = ($urandom_range(7) != 0);
      inst_ready     = ($urandom_range(3) != 0);
      redirect_valid = ($urandom_range(15) == 0);
      redirect_pc    = $urandom;
      step();
    end
    redirect_valid = 1'b0;
    chk("random_progress", n_xfer > 150, 1'b1);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch", perf_fetch_cnt, 32'(mdl_fetch));
    chk("perf_stall", perf_stall_cnt, 32'(mdl_stall));
`endif

    // Asynchronous reset mid-stream.
    fetch_en   = 1'b1;
    inst_ready = 1'b1;
    wait_valid("pre_reset_valid", 8);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_valid", inst_valid, 1'b0);
    chk("async_reset_pc", inst_pc, 32'h0);
    chk("async_reset_data", inst_data, 32'h0);
    chk("async_reset_mem_en", mem_en, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    chk("async_reset_perf_fetch", perf_fetch_cnt, 32'h0);
    chk("async_reset_perf_stall", perf_stall_cnt, 32'h0);
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("restart_idle", inst_valid, 1'b0);
    step();
    chk("restart_valid", inst_valid, 1'b1);
    chk("restart_pc", inst_pc, RST_PC);
    chk("restart_data", inst_data, 32'hA000_0000);
    step();
    chk("restart_pc1", inst_pc, 32'h4);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
